// File: rtl/snf_rxdat_pkg.sv
// Shared DAT flit layout and opcode helpers for the SN-F DAT receive channel.
package snf_rxdat_pkg;

    localparam int DAT_FLIT_W  = 64;
    localparam int DAT_OPC_LSB = 8;
    localparam int DAT_OPC_W   = 4;

    localparam int RXDAT_DEPTH_DEF = 4;
    localparam int RXDAT_CNT_W_DEF = 3;

    typedef logic [DAT_FLIT_W-1:0] dat_flit_t;
    typedef logic [DAT_OPC_W-1:0]  dat_opc_t;

    localparam dat_opc_t DAT_OPC_DATALCRDRETURN = 4'h0;

    function automatic dat_opc_t dat_opcode(input dat_flit_t flit);
        return flit[DAT_OPC_LSB +: DAT_OPC_W];
    endfunction

    function automatic logic is_lcrd_return(input dat_flit_t flit);
        return dat_opcode(flit) == DAT_OPC_DATALCRDRETURN;
    endfunction

endpackage

// File: rtl/snf_sync_fifo.sv
// Flop-based synchronous FIFO with wrap-around pointers and an occupancy count.
module snf_sync_fifo #(
    parameter int WIDTH = 64,
    parameter int DEPTH = 4,
    parameter int CNT_W = 3
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] rd_data,
    output logic [CNT_W-1:0] occ
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q;
    logic [PTR_W-1:0] rd_ptr_q;
    logic [CNT_W-1:0] occ_q;

    function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] ptr);
        return (ptr == PTR_W'(DEPTH - 1)) ? '0 : ptr + PTR_W'(1);
    endfunction

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            occ_q    <= '0;
        end else begin
            if (push) begin
                mem[wr_ptr_q] <= push_data;
                wr_ptr_q      <= next_ptr(wr_ptr_q);
            end
            if (pop) begin
                rd_ptr_q <= next_ptr(rd_ptr_q);
            end
            case ({push, pop})
                2'b10:   occ_q <= occ_q + CNT_W'(1);
                2'b01:   occ_q <= occ_q - CNT_W'(1);
                default: occ_q <= occ_q;
            endcase
        end
    end

    assign rd_data = mem[rd_ptr_q];
    assign occ     = occ_q;

endmodule

// File: rtl/snf_rxdat.sv
// SN-F CHI DAT receive channel: issues link credits upstream, buffers data flits
// toward snf_data_buffer and absorbs DataLCrdReturn flits.
module snf_rxdat
    import snf_rxdat_pkg::*;
#(
    parameter int RXDAT_DEPTH = RXDAT_DEPTH_DEF,
    parameter int RXDAT_CNT_W = RXDAT_CNT_W_DEF
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  rxdatflitpend,
    input  logic                  rxdatflitv,
    input  logic [DAT_FLIT_W-1:0] rxdatflit,
    output logic                  rxdatlcrdv,
    input  logic                  rxdat_crd_en,
    output logic                  rxdat_crd_idle,
    output logic                  rxdat_dbf_valid_s1,
    output logic [DAT_FLIT_W-1:0] rxdat_dbf_flit_s1,
    input  logic                  dbf_rxdat_rdy_s1,
    output logic                  rxdat_err_ovf
);

    logic [RXDAT_CNT_W-1:0] occ_q;
    logic [RXDAT_CNT_W-1:0] crd_out_q;
    logic [RXDAT_CNT_W:0]   crd_sum;
    logic                   lcrdv_q;
    logic                   err_q;
    logic                   grant_s0;
    logic                   flit_ok;
    logic                   push;
    logic                   pop;
    logic                   unused_flitpend;

    // The early flit hint carries no information this receiver needs.
    assign unused_flitpend = rxdatflitpend;

    // Credits are counted at grant time, so buffered plus in-flight never exceeds the FIFO.
    assign crd_sum  = {1'b0, occ_q} + {1'b0, crd_out_q};
    assign grant_s0 = rxdat_crd_en & (crd_sum < (RXDAT_CNT_W + 1)'(RXDAT_DEPTH));

    assign flit_ok = rxdatflitv & (crd_out_q != '0);
    assign push    = flit_ok & ~is_lcrd_return(rxdatflit);
    assign pop     = rxdat_dbf_valid_s1 & dbf_rxdat_rdy_s1;

    snf_sync_fifo #(
        .WIDTH (DAT_FLIT_W),
        .DEPTH (RXDAT_DEPTH),
        .CNT_W (RXDAT_CNT_W)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (push),
        .push_data (rxdatflit),
        .pop       (pop),
        .rd_data   (rxdat_dbf_flit_s1),
        .occ       (occ_q)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            crd_out_q <= '0;
            lcrdv_q   <= 1'b0;
            err_q     <= 1'b0;
        end else begin
            lcrdv_q <= grant_s0;
            case ({grant_s0, flit_ok})
                2'b10:   crd_out_q <= crd_out_q + RXDAT_CNT_W'(1);
                2'b01:   crd_out_q <= crd_out_q - RXDAT_CNT_W'(1);
                default: crd_out_q <= crd_out_q;
            endcase
            if (rxdatflitv && (crd_out_q == '0)) begin
                err_q <= 1'b1;
            end
        end
    end

    assign rxdatlcrdv         = lcrdv_q;
    assign rxdat_crd_idle     = (crd_out_q == '0) & ~lcrdv_q;
    assign rxdat_dbf_valid_s1 = (occ_q != '0);
    assign rxdat_err_ovf      = err_q;

endmodule

// File: tb/tb_snf_rxdat.sv
// Self-checking bench for snf_rxdat: random and directed traffic against a queue-based credit model.
module tb_snf_rxdat;
    import snf_rxdat_pkg::*;

    localparam int DEPTH = 4;
    localparam int CNT_W = 3;

    logic            clk = 1'b0;
    logic            rst;
    logic            rxdatflitpend;
    logic            rxdatflitv;
    dat_flit_t       rxdatflit;
    logic            rxdatlcrdv;
    logic            rxdat_crd_en;
    logic            rxdat_crd_idle;
    logic            rxdat_dbf_valid_s1;
    dat_flit_t       rxdat_dbf_flit_s1;
    logic            dbf_rxdat_rdy_s1;
    logic            rxdat_err_ovf;

    snf_rxdat #(.RXDAT_DEPTH(DEPTH), .RXDAT_CNT_W(CNT_W)) dut (
        .clk                (clk),
        .rst                (rst),
        .rxdatflitpend      (rxdatflitpend),
        .rxdatflitv         (rxdatflitv),
        .rxdatflit          (rxdatflit),
        .rxdatlcrdv         (rxdatlcrdv),
        .rxdat_crd_en       (rxdat_crd_en),
        .rxdat_crd_idle     (rxdat_crd_idle),
        .rxdat_dbf_valid_s1 (rxdat_dbf_valid_s1),
        .rxdat_dbf_flit_s1  (rxdat_dbf_flit_s1),
        .dbf_rxdat_rdy_s1   (dbf_rxdat_rdy_s1),
        .rxdat_err_ovf      (rxdat_err_ovf)
    );

    always #5 clk = ~clk;

    // Reference model: outstanding credits as an integer, buffered data as a queue.
    dat_flit_t m_q[$];
    int        m_crd;
    bit        m_lcrdv;
    bit        m_err;

    int n_checks = 0;
    int n_errors = 0;
    int pulse_cnt = 0;

    task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_q.delete();
        m_crd   = 0;
        m_lcrdv = 0;
        m_err   = 0;
    endtask

    task automatic model_edge(input bit v, input dat_flit_t f, input bit r, input bit en);
        bit grant;
        bit acc;
        grant = en && ((m_q.size() + m_crd) < DEPTH);
        acc   = v && (m_crd > 0);
        if (v && m_crd == 0) m_err = 1;
        if (r && m_q.size() > 0) void'(m_q.pop_front());
        if (acc && dat_opcode(f) != DAT_OPC_DATALCRDRETURN) m_q.push_back(f);
        m_crd   = m_crd + int'(grant) - int'(acc);
        m_lcrdv = grant;
    endtask

    task automatic check_outputs();
        check_val("valid", 64'(rxdat_dbf_valid_s1), 64'(m_q.size() != 0));
        if (m_q.size() != 0) check_val("head_flit", rxdat_dbf_flit_s1, m_q[0]);
        check_val("lcrdv", 64'(rxdatlcrdv), 64'(m_lcrdv));
        check_val("crd_idle", 64'(rxdat_crd_idle), 64'(m_crd == 0 && !m_lcrdv));
        check_val("err_ovf", 64'(rxdat_err_ovf), 64'(m_err));
        if (rxdatlcrdv) pulse_cnt++;
    endtask

    function automatic dat_flit_t make_flit(input bit lcrd);
        dat_flit_t f;
        dat_opc_t  opc;
        f = {$urandom, $urandom};
        opc = dat_opc_t'($urandom_range(1, 15));
        f[DAT_OPC_LSB +: DAT_OPC_W] = lcrd ? DAT_OPC_DATALCRDRETURN : opc;
        return f;
    endfunction

    task automatic step(input bit v, input dat_flit_t f, input bit r, input bit en);
        rxdatflitv       = v;
        rxdatflit        = f;
        dbf_rxdat_rdy_s1 = r;
        rxdat_crd_en     = en;
        rxdatflitpend    = v;
        @(posedge clk);
        model_edge(v, f, r, en);
        @(negedge clk);
        check_outputs();
    endtask

    task automatic check_reset_values();
        check_val("rst_lcrdv", 64'(rxdatlcrdv), 64'(0));
        check_val("rst_valid", 64'(rxdat_dbf_valid_s1), 64'(0));
        check_val("rst_flit", rxdat_dbf_flit_s1, 64'(0));
        check_val("rst_idle", 64'(rxdat_crd_idle), 64'(1));
        check_val("rst_err", 64'(rxdat_err_ovf), 64'(0));
    endtask

    task automatic random_phase(input int n, input int lcrd_pct, input int rdy_pct);
        bit v;
        bit r;
        bit en;
        for (int i = 0; i < n; i++) begin
            v  = (m_crd > 0) && ($urandom_range(0, 99) < 65);
            r  = $urandom_range(0, 99) < rdy_pct;
            en = $urandom_range(0, 99) < 90;
            step(v, make_flit($urandom_range(0, 99) < lcrd_pct), r, en);
        end
    endtask

    initial begin
        int guard;
        rst = 1'b1;
        rxdatflitpend = 0; rxdatflitv = 0; rxdatflit = '0;
        rxdat_crd_en = 1; dbf_rxdat_rdy_s1 = 0;
        model_reset();
        repeat (2) @(negedge clk);
        check_reset_values();
        rst = 1'b0;

        // Reset release: exactly DEPTH grants, then credits all outstanding.
        for (int i = 0; i < 6; i++) step(0, '0, 0, 1);
        check_val("init_grants", 64'(pulse_cnt), 64'(DEPTH));
        check_val("init_idle", 64'(rxdat_crd_idle), 64'(0));

        // Fill with data while blocked, then drain in order.
        for (int i = 0; i < DEPTH; i++) step(1, make_flit(0), 0, 1);
        for (int i = 0; i < 3; i++) step(0, '0, 0, 1);
        check_val("full_occ", 64'(m_q.size()), 64'(DEPTH));
        for (int i = 0; i < 8; i++) step(0, '0, 1, 1);

        // Credit return flit alone.
        step(1, make_flit(1), 0, 1);
        for (int i = 0; i < 3; i++) step(0, '0, 0, 1);

        random_phase(300, 20, 60);

        // Continuous traffic with drain always ready: push/pop at occ 1.
        for (int i = 0; i < 40; i++) step(m_crd > 0, make_flit(0), 1, 1);

        // Drop crd_en and have the transmitter return all credits.
        for (int i = 0; i < 4; i++) step(0, '0, 1, 1);
        guard = 0;
        while (m_crd > 0 && guard < 20) begin
            step(1, make_flit(1), 1, 0);
            guard++;
        end
        check_val("return_all_bound", 64'(m_crd), 64'(0));
        for (int i = 0; i < 3; i++) step(0, '0, 1, 0);
        check_val("idle_after_return", 64'(rxdat_crd_idle), 64'(1));

        // Flit with no outstanding credit.
        step(1, make_flit(0), 1, 0);
        for (int i = 0; i < 3; i++) step(0, '0, 1, 0);
        check_val("ovf_sticky", 64'(rxdat_err_ovf), 64'(1));

        random_phase(100, 15, 50);

        // Asynchronous reset mid-operation.
        rst = 1'b1;
        #1;
        model_reset();
        check_reset_values();
        @(negedge clk);
        rst = 1'b0;
        random_phase(150, 20, 70);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

// File: doc/snf_rxdat.md
# snf_rxdat

SN-F CHI DAT receive channel: the receiver counterpart of the SN-F DAT transmit channel. It grants link-layer credits to the upstream DAT transmitter and accepts DAT flits into a credit-sized FIFO. Data flits go to snf_data_buffer over a valid/ready handshake; DataLCrdReturn flits are absorbed. It sits between snf_link (RXDAT pins and link state) and snf_data_buffer.

## Interface
Parameters:
- RXDAT_DEPTH, 4, FIFO entries and maximum link credits; legal range 1..15.
- RXDAT_CNT_W, 3, width of occupancy and credit counters; must hold 0..RXDAT_DEPTH.

Ports:
- clk  in  1  clock; single clock domain.
- rst  in  1  asynchronous, active-high reset.
- rxdatflitpend  in  1  early flit indication; ignored.
- rxdatflitv  in  1  DAT flit valid from snf_link.
- rxdatflit  in  `CHIE_DAT_FLIT_RANGE  DAT flit.
- rxdatlcrdv  out  1  one link credit granted to the transmitter; one-cycle pulse per credit.
- rxdat_crd_en  in  1  from snf_link; high while the RX link is in RUN and credits may be issued.
- rxdat_crd_idle  out  1  no credits outstanding and none in flight; snf_link uses it for deactivation.
- rxdat_dbf_valid_s1  out  1  FIFO head valid toward snf_data_buffer.
- rxdat_dbf_flit_s1  out  `CHIE_DAT_FLIT_RANGE  FIFO head flit.
- dbf_rxdat_rdy_s1  in  1  snf_data_buffer accepts the head this cycle.
- rxdat_err_ovf  out  1  sticky error: a flit arrived with no outstanding credit.

## Operation
- State: FIFO of RXDAT_DEPTH entries with wrap-around read/write pointers, occupancy count occ_q, outstanding-credit count crd_out_q, registered grant lcrdv_q, and sticky err_q.
- Credit issue:
  - grant_s0 = rxdat_crd_en & (occ_q + crd_out_q < RXDAT_DEPTH).
  - lcrdv_q <= grant_s0; rxdatlcrdv = lcrdv_q.
  - crd_out_q counts each credit when grant_s0 is computed, before the registered pulse appears on rxdatlcrdv.
  - Invariant: occ_q + crd_out_q ≤ RXDAT_DEPTH at all times.
- Flit arrival (rxdatflitv = 1):
  - If crd_out_q == 0: set err_q and drop the flit. No counter changes.
  - Otherwise crd_out_q decrements.
  - Opcode == `CHIE_DAT_OPC_DATALCRDRETURN: the flit is discarded and the credit is retired.
  - Any other opcode: the flit is written at the write pointer and occ_q increments.
- Drain: when rxdat_dbf_valid_s1 & dbf_rxdat_rdy_s1, the read pointer advances and occ_q decrements.
- rxdat_dbf_valid_s1 = (occ_q != 0). rxdat_dbf_flit_s1 = entry at the read pointer. Both are combinational from registers.
- rxdat_crd_idle = (crd_out_q == 0) & ~lcrdv_q.
- Counter arithmetic:
  - crd_out_q next = crd_out_q + grant_s0 − accepted_flit. Simultaneous increment and decrement holds the value.
  - occ_q next = occ_q + push − pop. Simultaneous push and pop holds the value.
  - Pointers wrap from RXDAT_DEPTH−1 to 0.
- Boundary conditions:
  - FIFO full with a pop: the freed slot yields a new grant the following cycle.
  - rxdat_crd_en falling: grants stop immediately. Already-counted credits remain outstanding until the transmitter returns them as flits.
  - Push and pop on the same edge with occ_q == 1: the head advances and the new flit is stored. No bubble.
  - Empty FIFO: valid stays low; dbf_rxdat_rdy_s1 is ignored.

## Timing
- Reset values: rxdatlcrdv = 0, rxdat_dbf_valid_s1 = 0, rxdat_dbf_flit_s1 = 0, rxdat_crd_idle = 1, rxdat_err_ovf = 0. All pointers and counters are 0.
- Reset asserted mid-operation: all state clears asynchronously and FIFO contents are discarded.
- After rst deasserts with rxdat_crd_en high: grant_s0 is high in cycles 0..DEPTH−1, and rxdatlcrdv pulses in cycles 1..DEPTH. This returns one credit per cycle.
- Flit latency: a flit on rxdatflitv in cycle N is visible on rxdat_dbf_valid_s1 in cycle N+1 (an empty FIFO gives no bypass).
- Credit recycle: a pop in cycle N gives grant_s0 in N+1 and rxdatlcrdv in N+2.
- rxdat_err_ovf: asserts the cycle after the offending flit and holds until reset.

## Structure
- The DAT opcode field range and the DataLCrdReturn encoding come from chie_defines.v.
- RXDAT_DEPTH and RXDAT_CNT_W defaults live in snf_param.v.
- The only natural sub-module is snf_sync_fifo: a parameterised width/depth FIFO with flop storage, push/pop and occupancy. The credit logic stays in snf_rxdat.

## Test plan
- Reset release, crd_en = 1, DEPTH = 4 → rxdatlcrdv pulses exactly 4 times in cycles 1–4. Then crd_out = 4 and rxdat_crd_idle = 0.
- Send 4 data flits with rdy = 0 → occ = 4, no further credits. Raise rdy → 4 flits drain in order, unchanged; 4 new credits follow, each 2 cycles after its pop.
- Send a DataLCrdReturn flit → nothing appears on rxdat_dbf_valid_s1; crd_out decrements by 1; a new grant follows within 2 cycles while crd_en is high.
- Drop crd_en, then transmitter returns all 4 credits as DataLCrdReturn → no rxdatlcrdv pulses; rxdat_crd_idle rises the cycle after the last return.
- Send a flit when crd_out = 0 → flit dropped, rxdat_err_ovf = 1 next cycle and stays high; occ unchanged.
- Continuous traffic with rdy = 1 and a simultaneous push/pop at occ = 1 → no lost or duplicated flits; rxdat_dbf_valid_s1 stays high; pointers wrap correctly over more than 10 flits.
